// File: rtl/control_unit_pkg.sv
// Shared encodings for the RISCBlade multicycle controller: FSM states,
// opcode class constants, datapath select encodings and the control bundle.
`timescale 1ns/1ps
package control_unit_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        RTYPE_EX = 4'd2,
        RTYPE_WB = 4'd3,
        MEMADR   = 4'd4,
        ADDI_WB  = 4'd5,
        MEMREAD  = 4'd6,
        MEM_WB   = 4'd7,
        MEMWRITE = 4'd8,
        BRANCH   = 4'd9,
        JAL_JUMP = 4'd10,
        JAL_LINK = 4'd11
    } state_t;

    // Instruction class, taken from op[2:0]; op[3] picks the variant.
    localparam logic [2:0] OP_R    = 3'b000;
    localparam logic [2:0] OP_IMEM = 3'b001;
    localparam logic [2:0] OP_SW   = 3'b010;
    localparam logic [2:0] OP_BR   = 3'b011;
    localparam logic [2:0] OP_JAL  = 3'b100;

    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_TWO    = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    localparam logic SRCA_PC     = 1'b0;
    localparam logic SRCA_REG    = 1'b1;
    localparam logic IORD_PC     = 1'b0;
    localparam logic IORD_ALU    = 1'b1;
    localparam logic REGSEL_ALU  = 1'b0;
    localparam logic REGSEL_MEM  = 1'b1;

    typedef struct packed {
        logic       branch_out;
        logic       pc_reset;
        logic       iord;
        logic       mem_write;
        logic       ir_en;
        logic       reg_data_sel;
        logic       reg_write;
        logic       srca;
        logic [1:0] srcb;
        logic       alu_op;
    } ctrl_t;

endpackage

// File: rtl/control_unit.sv
// Multicycle FSM controller: sequences fetch/decode/execute/memory/writeback
// and decodes the current state into the datapath's selects and enables.
`timescale 1ns/1ps
module control_unit
    import control_unit_pkg::*;
(
    input  logic       CLK,
    input  logic       reset,
    input  logic [3:0] op,
    output logic       BranchOut,
    output logic       PCReset,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IR_EN,
    output logic       RegDataSel,
    output logic       RegWrite,
    output logic       SRCA,
    output logic [1:0] SRCB,
    output logic       ALUOp
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;

    // NOTE: sequential state uses non-blocking assignment; reset is async so
    // an abort takes effect without waiting for a clock edge.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = DECODE;
            DECODE: begin
                case (op[2:0])
                    OP_R:            state_d = RTYPE_EX;
                    OP_IMEM, OP_SW:  state_d = MEMADR;
                    OP_BR:           state_d = BRANCH;
                    OP_JAL:          state_d = JAL_JUMP;
                    default:         state_d = FETCH;
                endcase
            end
            RTYPE_EX: state_d = RTYPE_WB;
            MEMADR: begin
                if (op[2:0] == OP_SW) begin
                    state_d = MEMWRITE;
                end else if (op[3]) begin
                    state_d = MEMREAD;
                end else begin
                    state_d = ADDI_WB;
                end
            end
            MEMREAD:  state_d = MEM_WB;
            JAL_JUMP: state_d = JAL_LINK;
            default:  state_d = FETCH;
        endcase
    end

    // While reset is high only PCReset is driven, so no write enable can leak.
    always_comb begin
        ctrl = '0;
        if (reset) begin
            ctrl.pc_reset = 1'b1;
        end else begin
            case (state_q)
                FETCH: begin
                    ctrl.ir_en  = 1'b1;
                    ctrl.iord   = IORD_PC;
                    ctrl.srca   = SRCA_PC;
                    ctrl.srcb   = SRCB_TWO;
                    ctrl.alu_op = ALU_ADD;
                end
                DECODE: begin
                    ctrl.srca   = SRCA_PC;
                    ctrl.srcb   = SRCB_IMM_SH;
                    ctrl.alu_op = ALU_ADD;
                end
                RTYPE_EX: begin
                    ctrl.srca   = SRCA_REG;
                    ctrl.srcb   = SRCB_REGB;
                    ctrl.alu_op = op[3];
                end
                RTYPE_WB, ADDI_WB, JAL_LINK: begin
                    ctrl.reg_write    = 1'b1;
                    ctrl.reg_data_sel = REGSEL_ALU;
                end
                MEMADR: begin
                    ctrl.srca   = SRCA_REG;
                    ctrl.srcb   = SRCB_IMM;
                    ctrl.alu_op = ALU_ADD;
                end
                MEMREAD: begin
                    ctrl.iord = IORD_ALU;
                end
                MEM_WB: begin
                    ctrl.reg_write    = 1'b1;
                    ctrl.reg_data_sel = REGSEL_MEM;
                end
                MEMWRITE: begin
                    ctrl.iord      = IORD_ALU;
                    ctrl.mem_write = 1'b1;
                end
                BRANCH: begin
                    ctrl.srca       = SRCA_REG;
                    ctrl.srcb       = SRCB_REGB;
                    ctrl.alu_op     = ALU_SUB;
                    ctrl.branch_out = 1'b1;
                end
                JAL_JUMP: begin
                    // B reads r0, so ALUOut captures the return address.
                    ctrl.branch_out = 1'b1;
                    ctrl.srca       = SRCA_PC;
                    ctrl.srcb       = SRCB_REGB;
                    ctrl.alu_op     = ALU_ADD;
                end
                default: ctrl = '0;
            endcase
        end
    end

    assign BranchOut  = ctrl.branch_out;
    assign PCReset    = ctrl.pc_reset;
    assign IorD       = ctrl.iord;
    assign MemWrite   = ctrl.mem_write;
    assign IR_EN      = ctrl.ir_en;
    assign RegDataSel = ctrl.reg_data_sel;
    assign RegWrite   = ctrl.reg_write;
    assign SRCA       = ctrl.srca;
    assign SRCB       = ctrl.srcb;
    assign ALUOp      = ctrl.alu_op;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: an instruction-level model queues the
// expected per-cycle control words; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_control_unit;

    typedef struct packed {
        logic       branch_out;
        logic       pc_reset;
        logic       iord;
        logic       mem_write;
        logic       ir_en;
        logic       reg_data_sel;
        logic       reg_write;
        logic       srca;
        logic [1:0] srcb;
        logic       alu_op;
    } vec_t;

    logic       CLK;
    logic       reset;
    logic [3:0] op;
    logic       BranchOut, PCReset, IorD, MemWrite, IR_EN, RegDataSel, RegWrite, SRCA, ALUOp;
    logic [1:0] SRCB;

    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_cycle  = 0;
    bit   mon_en   = 1'b0;

    control_unit dut (
        .CLK        (CLK),
        .reset      (reset),
        .op         (op),
        .BranchOut  (BranchOut),
        .PCReset    (PCReset),
        .IorD       (IorD),
        .MemWrite   (MemWrite),
        .IR_EN      (IR_EN),
        .RegDataSel (RegDataSel),
        .RegWrite   (RegWrite),
        .SRCA       (SRCA),
        .SRCB       (SRCB),
        .ALUOp      (ALUOp)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end

    function automatic vec_t sample();
        vec_t s;
        s.branch_out   = BranchOut;
        s.pc_reset     = PCReset;
        s.iord         = IorD;
        s.mem_write    = MemWrite;
        s.ir_en        = IR_EN;
        s.reg_data_sel = RegDataSel;
        s.reg_write    = RegWrite;
        s.srca         = SRCA;
        s.srcb         = SRCB;
        s.alu_op       = ALUOp;
        return s;
    endfunction

    task automatic check(input string name, input vec_t act, input vec_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d op=%b: got %b required %b (fields br,pcr,iord,mw,ir,rds,rw,srca,srcb,aluop)",
                     name, n_cycle, op, act, exp);
        end
    endtask

    // Reference model: each instruction class is a fixed list of step control words.
    function automatic vec_t reset_word();
        vec_t w = '0;
        w.pc_reset = 1'b1;
        return w;
    endfunction

    task automatic push_instr(input logic [3:0] o);
        vec_t w;
        w = '0; w.ir_en = 1'b1; w.srcb = 2'b01;                  exp_q.push_back(w); // fetch, PC+2
        w = '0; w.srcb = 2'b11;                                  exp_q.push_back(w); // decode, target
        case (o[2:0])
            3'b000: begin
                w = '0; w.srca = 1'b1; w.alu_op = o[3];          exp_q.push_back(w);
                w = '0; w.reg_write = 1'b1;                      exp_q.push_back(w);
            end
            3'b001: begin
                w = '0; w.srca = 1'b1; w.srcb = 2'b10;           exp_q.push_back(w);
                if (o[3]) begin
                    w = '0; w.iord = 1'b1;                       exp_q.push_back(w);
                    w = '0; w.reg_write = 1'b1; w.reg_data_sel = 1'b1; exp_q.push_back(w);
                end else begin
                    w = '0; w.reg_write = 1'b1;                  exp_q.push_back(w);
                end
            end
            3'b010: begin
                w = '0; w.srca = 1'b1; w.srcb = 2'b10;           exp_q.push_back(w);
                w = '0; w.iord = 1'b1; w.mem_write = 1'b1;       exp_q.push_back(w);
            end
            3'b011: begin
                w = '0; w.srca = 1'b1; w.alu_op = 1'b1; w.branch_out = 1'b1; exp_q.push_back(w);
            end
            3'b100: begin
                w = '0; w.branch_out = 1'b1;                     exp_q.push_back(w);
                w = '0; w.reg_write = 1'b1;                      exp_q.push_back(w);
            end
            default: ;
        endcase
    endtask

    // Called in the FETCH cycle just after the clock edge; leaves the bench
    // in the following FETCH cycle at the same phase.
    task automatic run_instr(input logic [3:0] o);
        int n0;
        int n;
        n0 = exp_q.size();
        push_instr(o);
        n = exp_q.size() - n0;
        op = o;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Start a JAL, then reset asynchronously in the middle of JAL_JUMP.
    task automatic abort_jal(input logic [3:0] o);
        push_instr(o);
        void'(exp_q.pop_back());               // JAL_LINK never happens
        op = o;
        repeat (2) @(posedge CLK);
        @(negedge CLK);                        // monitor sees JAL_JUMP here
        #1;
        reset = 1'b1;
        #1;
        check("async_reset_drop", sample(), reset_word());
        exp_q.push_back(reset_word());
        @(posedge CLK);
        @(negedge CLK);
        @(posedge CLK);
        #1;
        reset = 1'b0;
    endtask

    initial begin : monitor
        vec_t exp;
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                n_cycle++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL scoreboard_underflow cycle %0d: got %b required <nothing queued>",
                             n_cycle, sample());
                end else begin
                    exp = exp_q.pop_front();
                    check("ctrl_word", sample(), exp);
                end
            end
        end
    end

    initial begin : driver
        logic [3:0] directed [12];
        directed = '{4'b0000, 4'b1000, 4'b0001, 4'b1001, 4'b0010, 4'b1010,
                     4'b0011, 4'b1011, 4'b0100, 4'b1100, 4'b0101, 4'b1111};
        reset = 1'b1;
        op    = 4'b0000;
        exp_q.push_back(reset_word());
        mon_en = 1'b1;
        @(negedge CLK);
        @(posedge CLK);
        #1;
        reset = 1'b0;

        foreach (directed[i]) run_instr(directed[i]);
        abort_jal(4'b0100);
        run_instr(4'b0000);
        abort_jal(4'b1100);
        run_instr(4'b1001);

        for (int i = 0; i < 60; i++) begin
            run_instr(4'($urandom_range(0, 15)));
        end

        mon_en = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_leftover: got %0d queued words required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
